serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled at the rising edge of clk.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-007 SHALL have port borrow_in  input  1  initial borrow; sampled only when start is accepted.
REQ-008 SHALL have port diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
REQ-009 SHALL have port borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned).
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  single-cycle pulse; diff and borrow_out are valid.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 SHALL be accepted: load a and b into shift registers, load the borrow flop from borrow_in, clear the bit counter, go to RUN.
REQ-014 In RUN, each cycle SHALL feed the LSBs of both shift registers and the borrow flop into one full-subtractor cell, shift the difference bit into diff from the MSB end, register the cell borrow, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), then go to DONE.
REQ-016 In DONE, done=1 for exactly one cycle, then go to IDLE; done SHALL assert on the (WIDTH+1)th rising edge after the accepting edge.
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 start while busy=1 SHALL be ignored, with no effect on state or results.
REQ-019 start held high through DONE SHALL be accepted on the first edge in IDLE, giving back-to-back operations with one idle cycle between them.
REQ-020 diff and borrow_out SHALL hold their last completed values from DONE until the next start is accepted; intermediate diff values during RUN are don't-care.
REQ-021 Changes on a, b or borrow_in after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-022 On rst_n low, the block SHALL immediately force the FSM to IDLE and set diff=0, borrow_out=0, busy=0, done=0, and clear the counter and shift registers.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-024 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output ovf (1 bit), equal to the XOR of the borrow into the MSB and borrow_out, latched with borrow_out in DONE (signed two's-complement overflow), and reset to 0.
REQ-025 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-026 The FSM state enum (IDLE/RUN/DONE) and the counter-width helper constant SHALL reside in shared package serial_sub_pkg.
REQ-027 The bit cell SHALL be the team's existing combinational FullSubtractor (ports A, B, C, D, Borr_out), instantiated once as the only sub-module.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, borrow_in=0 -> done on the 9th edge after start, diff=0x1E, borrow_out=0.
REQ-029 WIDTH=8, a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1; with the macro defined, ovf=0.
REQ-030 WIDTH=8, a=0x80, b=0x01, borrow_in=0, macro defined -> diff=0x7F, borrow_out=0, ovf=1.
REQ-031 Pulse start again during RUN with different operands -> ignored; first result unchanged; exactly one done.
REQ-032 Assert rst_n=0 at RUN cycle 4 -> busy=0, done=0, diff=0 immediately; the next start with a=0x10, b=0x10, borrow_in=1 -> diff=0xFF, borrow_out=1.
REQ-033 Hold start=1 continuously -> done pulses every WIDTH+2 cycles, and each result matches the operands present at its accepting edge.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;
  // Bit counter sized once for the largest legal operand width.
  localparam int CNT_W     = $clog2(MAX_WIDTH);

endpackage

// File: rtl/FullSubtractor.sv
// Combinational one-bit full subtractor: D = A - B - C, Borr_out is the borrow out.
module FullSubtractor (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D,
  output logic Borr_out
);

  assign D        = A ^ B ^ C;
  assign Borr_out = (~A & B) | (~(A ^ B) & C);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled with macro SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_b;
`ifdef SERIAL_SUB_OVF_EN
  logic             brw_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  FullSubtractor u_cell (
    .A        (a_sr[0]),
    .B        (b_sr[0]),
    .C        (brw),
    .D        (cell_d),
    .Borr_out (cell_b)
  );

  // Serial datapath: operands shift right, difference bits enter from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      brw        <= borrow_in;
      cnt        <= '0;
    end else if (step) begin
      a_sr       <= a_sr >> 1;
      b_sr       <= b_sr >> 1;
      diff_sr    <= {cell_d, diff_sr[WIDTH-1:1]};
      brw        <= cell_b;
      cnt        <= cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Borrow entering the sign bit; XOR with the final borrow flags signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brw_msb <= 1'b0;
    end else if (step && (cnt == LAST_BIT)) begin
      brw_msb <= brw;
    end
  end
`endif

  // Result registers: updated only as an operation completes, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      done <= finish;
      if (finish) begin
        diff       <= diff_sr;
        borrow_out <= brw;
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= brw_msb ^ brw;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor; checks ovf too when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam logic [W-1:0] MAXV = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bi, input int acc);
    exp_t   e;
    longint ux, uy, sx, sy, sres;
    ux    = longint'(x);
    uy    = longint'(y);
    sx    = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy    = y[W-1] ? uy - (longint'(1) << W) : uy;
    sres  = sx - sy - longint'(bi);
    e.d   = W'(ux - uy - longint'(bi));
    e.bo  = (ux < uy + longint'(bi));
    e.ov  = (sres < -(longint'(1) << (W - 1))) || (sres > (longint'(1) << (W - 1)) - 1);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("done_without_op", 32'(done), 32'(0));
      end else begin
        mon_e = q.pop_front();
        chk("diff", 32'(diff), 32'(mon_e.d));
        chk("borrow_out", 32'(borrow_out), 32'(mon_e.bo));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
        chk("done_latency", 32'(cyc - mon_e.acc), 32'(W + 1));
      end
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    a         = x;
    b         = y;
    borrow_in = bi;
    start     = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    q.push_back(model(x, y, bi, cyc));
    chk("busy_after_start", 32'(busy), 32'(1));
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
  endtask

  task automatic finish_op();
    wait_edge(last_acc + W + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] x, y;
    int           next_acc;
    #12;
    chk("reset_diff", 32'(diff), 32'(0));
    chk("reset_borrow_out", 32'(borrow_out), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0);
    finish_op();
    wait_edge(cyc + 3);
    chk("diff_hold", 32'(diff), 32'(8'h1E));
    chk("borrow_out_hold", 32'(borrow_out), 32'(0));
    chk("done_idle", 32'(done), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));

    issue(8'h00, 8'h01, 1'b0);
    finish_op();
    issue(8'h80, 8'h01, 1'b0);
    finish_op();
    issue(MAXV, MAXV, 1'b1);
    finish_op();

    // A start pulse during RUN must be ignored.
    issue(8'h33, 8'h11, 1'b0);
    wait_edge(last_acc + 3);
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    borrow_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op();
    wait_edge(cyc + W + 3);
    chk("no_extra_done", 32'(q.size()), 32'(0));
    chk("busy_after_ignored", 32'(busy), 32'(0));

    // Reset in the middle of RUN aborts without a done pulse.
    issue(8'h5A, 8'h3C, 1'b0);
    wait_edge(last_acc + 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_diff", 32'(diff), 32'(0));
    chk("abort_borrow_out", 32'(borrow_out), 32'(0));
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(last_acc + W + 4);
    issue(8'h10, 8'h10, 1'b1);
    finish_op();

    // start held high: one acceptance every W+2 edges, each with its own operands.
    next_acc = 0;
    for (int k = 0; k < 4 * (W + 2); k++) begin
      @(negedge clk);
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
      start     = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0 || cyc == next_acc) begin
        q.push_back(model(a, b, borrow_in, cyc));
        next_acc = cyc + W + 2;
        last_acc = cyc;
      end
    end
    @(negedge clk);
    start = 1'b0;
    finish_op();

    repeat (30) begin
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(0, 4))
        0: x = '0;
        1: y = MAXV;
        2: begin x = {1'b1, {(W-1){1'b0}}}; end
        default: ;
      endcase
      issue(x, y, 1'($urandom));
      finish_op();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    wait_edge(cyc + W + 4);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
